// File: rtl/alu_issue_ctrl.sv
// Four-state execute sequencer for the 16-bit extended ALU: accepts a request,
// reads the register file, drives the ALU, then writes the result and flags back.
module alu_issue_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_op,
    input  logic [1:0]  req_rs,
    input  logic [1:0]  req_rt,
    input  logic [1:0]  req_rd,
    input  logic [7:0]  req_imm,
    input  logic        req_use_imm,
    output logic [1:0]  rf_raddr1,
    output logic [1:0]  rf_raddr2,
    input  logic [15:0] rf_rdata1,
    input  logic [15:0] rf_rdata2,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    output logic        alu_bnegate,
    output logic [2:0]  alu_ctrl,
    input  logic        alu_zero,
    input  logic        alu_ovf,
    input  logic        alu_cout,
    input  logic [15:0] alu_rez,
    output logic        rf_we,
    output logic [1:0]  rf_waddr,
    output logic [15:0] rf_wdata,
    output logic        flag_z,
    output logic        flag_v,
    output logic        flag_c,
    output logic        err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_READ = 2'd1,
        S_EXEC = 2'd2,
        S_WB   = 2'd3
    } state_t;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_NOR  = 4'd5;
    localparam logic [3:0] OP_SLT  = 4'd6;
    localparam logic [3:0] OP_SLTI = 4'd7;
    localparam logic [3:0] OP_MOD  = 4'd8;

    state_t      state, state_next;

    logic [3:0]  op_q;
    logic [1:0]  rs_q, rt_q, rd_q;
    logic [7:0]  imm_q;
    logic        use_imm_q;
    logic        illegal_q;
    logic [2:0]  ctrl_q;
    logic        bneg_q;
    logic [15:0] opa_q, opb_q;
    logic [15:0] rez_q;
    logic        zero_q, ovf_q, cout_q;
    logic        z_q, v_q, c_q;

    logic [2:0]  dec_ctrl;
    logic        dec_bneg;
    logic        dec_illegal;
    logic [15:0] imm_sext;
    logic        wb_ok;
    logic        arith_flags;

    always_comb begin
        dec_ctrl    = 3'b000;
        dec_bneg    = 1'b0;
        dec_illegal = 1'b0;
        unique case (req_op)
            OP_ADD:  dec_ctrl = 3'b010;
            OP_SUB:  begin dec_ctrl = 3'b010; dec_bneg = 1'b1; end
            OP_AND:  dec_ctrl = 3'b000;
            OP_OR:   dec_ctrl = 3'b001;
            OP_XOR:  dec_ctrl = 3'b100;
            OP_NOR:  dec_ctrl = 3'b101;
            OP_SLT:  begin dec_ctrl = 3'b011; dec_bneg = 1'b1; end
            OP_SLTI: dec_ctrl = 3'b110;
            OP_MOD:  dec_ctrl = 3'b111;
            default: dec_illegal = 1'b1;
        endcase
    end

    assign imm_sext    = {{8{imm_q[7]}}, imm_q};
    // A zero divisor is caught here rather than at decode because it depends on register data.
    assign wb_ok       = !illegal_q && !((op_q == OP_MOD) && (opb_q == 16'h0000));
    assign arith_flags = (op_q == OP_ADD) || (op_q == OP_SUB) || (op_q == OP_SLT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        req_ready  = 1'b0;
        rf_we      = 1'b0;
        err        = 1'b0;
        unique case (state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_next = S_READ;
                end
            end
            S_READ: state_next = S_EXEC;
            S_EXEC: state_next = S_WB;
            S_WB: begin
                rf_we      = wb_ok && (rd_q != 2'd0);
                err        = !wb_ok;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q      <= '0;
            rs_q      <= '0;
            rt_q      <= '0;
            rd_q      <= '0;
            imm_q     <= '0;
            use_imm_q <= 1'b0;
            illegal_q <= 1'b0;
            ctrl_q    <= '0;
            bneg_q    <= 1'b0;
        end else if (state == S_IDLE && req_valid) begin
            op_q      <= req_op;
            rs_q      <= req_rs;
            rt_q      <= req_rt;
            rd_q      <= req_rd;
            imm_q     <= req_imm;
            use_imm_q <= req_use_imm;
            illegal_q <= dec_illegal;
            ctrl_q    <= dec_ctrl;
            bneg_q    <= dec_bneg;
        end
    end

    // SLTI always takes the immediate, whatever use_imm says.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opa_q <= '0;
            opb_q <= '0;
        end else if (state == S_READ) begin
            opa_q <= rf_rdata1;
            opb_q <= (use_imm_q || (op_q == OP_SLTI)) ? imm_sext : rf_rdata2;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rez_q  <= '0;
            zero_q <= 1'b0;
            ovf_q  <= 1'b0;
            cout_q <= 1'b0;
        end else if (state == S_EXEC) begin
            rez_q  <= alu_rez;
            zero_q <= alu_zero;
            ovf_q  <= alu_ovf;
            cout_q <= alu_cout;
        end
    end

    // Flags follow a legal op even when rd==0 suppresses the register write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            z_q <= 1'b0;
            v_q <= 1'b0;
            c_q <= 1'b0;
        end else if (state == S_WB && wb_ok) begin
            z_q <= zero_q;
            v_q <= arith_flags ? ovf_q  : 1'b0;
            c_q <= arith_flags ? cout_q : 1'b0;
        end
    end

    assign rf_raddr1   = rs_q;
    assign rf_raddr2   = rt_q;
    assign alu_a       = opa_q;
    assign alu_b       = opb_q;
    assign alu_ctrl    = ctrl_q;
    assign alu_bnegate = bneg_q;
    assign rf_waddr    = rd_q;
    assign rf_wdata    = rez_q;
    assign flag_z      = z_q;
    assign flag_v      = v_q;
    assign flag_c      = c_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a behavioural register file and ALU
// standing in for the real datapath blocks on the other side of the ports.
module tb_alu_issue_ctrl;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_op;
    logic [1:0]  req_rs, req_rt, req_rd;
    logic [7:0]  req_imm;
    logic        req_use_imm;
    logic [1:0]  rf_raddr1, rf_raddr2;
    logic [15:0] rf_rdata1, rf_rdata2;
    logic [15:0] alu_a, alu_b;
    logic        alu_bnegate;
    logic [2:0]  alu_ctrl;
    logic        alu_zero, alu_ovf, alu_cout;
    logic [15:0] alu_rez;
    logic        rf_we;
    logic [1:0]  rf_waddr;
    logic [15:0] rf_wdata;
    logic        flag_z, flag_v, flag_c;
    logic        err;

    int errors = 0;
    int checks = 0;

    logic [15:0] rf_mem [4];

    alu_issue_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_rs(req_rs), .req_rt(req_rt), .req_rd(req_rd),
        .req_imm(req_imm), .req_use_imm(req_use_imm),
        .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
        .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
        .alu_a(alu_a), .alu_b(alu_b), .alu_bnegate(alu_bnegate), .alu_ctrl(alu_ctrl),
        .alu_zero(alu_zero), .alu_ovf(alu_ovf), .alu_cout(alu_cout), .alu_rez(alu_rez),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .flag_z(flag_z), .flag_v(flag_v), .flag_c(flag_c), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign rf_rdata1 = (rf_raddr1 == 2'd0) ? 16'h0000 : rf_mem[rf_raddr1];
    assign rf_rdata2 = (rf_raddr2 == 2'd0) ? 16'h0000 : rf_mem[rf_raddr2];

    // Reference ALU: adder-based ADD/SUB/SLT, bitwise ops, signed SLTI, unsigned MOD.
    logic [15:0] bb;
    logic [16:0] sum;
    logic        sovf;
    always_comb begin
        bb       = alu_bnegate ? ~alu_b : alu_b;
        sum      = {1'b0, alu_a} + {1'b0, bb} + {16'h0000, alu_bnegate};
        sovf     = (alu_a[15] == bb[15]) && (sum[15] != alu_a[15]);
        alu_rez  = 16'h0000;
        alu_ovf  = 1'b0;
        alu_cout = 1'b0;
        case (alu_ctrl)
            3'b010: begin alu_rez = sum[15:0]; alu_ovf = sovf; alu_cout = sum[16]; end
            3'b011: begin alu_rez = {15'h0, sum[15] ^ sovf}; alu_ovf = sovf; alu_cout = sum[16]; end
            3'b000: alu_rez = alu_a & alu_b;
            3'b001: alu_rez = alu_a | alu_b;
            3'b100: alu_rez = alu_a ^ alu_b;
            3'b101: alu_rez = ~(alu_a | alu_b);
            3'b110: alu_rez = ($signed(alu_a) < $signed(alu_b)) ? 16'h0001 : 16'h0000;
            3'b111: alu_rez = (alu_b == 16'h0000) ? 16'h0000 : (alu_a % alu_b);
            default: alu_rez = 16'h0000;
        endcase
        alu_zero = (alu_rez == 16'h0000);
    end

    typedef struct {
        logic [3:0]  op;
        logic [1:0]  rd;
        logic [7:0]  imm;
        logic        use_imm;
        logic [15:0] ra;
        logic [15:0] rb;
        logic        chk_alu;
        logic [2:0]  ctrl;
        logic        bneg;
        logic [15:0] exp_b;
        logic        we;
        logic        err;
        logic [15:0] wdata;
        logic        z;
        logic        v;
        logic        c;
    } vec_t;

    localparam int NVEC = 14;
    vec_t vecs [NVEC];

    task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%04h, expected 0x%04h", name, act, exp);
        end
    endtask

    // Issues one request from IDLE (entered and left on a negedge) and checks each stage.
    task automatic applyStimulus(input int idx);
        vec_t v;
        string p;
        v = vecs[idx];
        p = $sformatf("v%0d", idx);
        rf_mem[1]   = v.ra;
        rf_mem[2]   = v.rb;
        checkOutput({p, "_ready_idle"}, {15'h0, req_ready}, 16'h0001);
        req_op      = v.op;
        req_rs      = 2'd1;
        req_rt      = 2'd2;
        req_rd      = v.rd;
        req_imm     = v.imm;
        req_use_imm = v.use_imm;
        req_valid   = 1'b1;
        @(posedge clk);
        #1;
        req_valid   = 1'b0;
        req_op      = 4'hF;
        req_rs      = 2'd3;
        req_rt      = 2'd3;
        req_rd      = 2'd0;
        req_imm     = 8'h5A;
        req_use_imm = 1'b0;
        @(negedge clk);
        checkOutput({p, "_ready_read"}, {15'h0, req_ready}, 16'h0000);
        checkOutput({p, "_raddr1"}, {14'h0, rf_raddr1}, 16'h0001);
        @(negedge clk);
        if (v.chk_alu) begin
            checkOutput({p, "_alu_a"}, alu_a, v.ra);
            checkOutput({p, "_alu_b"}, alu_b, v.exp_b);
            checkOutput({p, "_alu_ctrl"}, {13'h0, alu_ctrl}, {13'h0, v.ctrl});
            checkOutput({p, "_bnegate"}, {15'h0, alu_bnegate}, {15'h0, v.bneg});
        end
        checkOutput({p, "_we_exec"}, {15'h0, rf_we}, 16'h0000);
        @(negedge clk);
        checkOutput({p, "_we"}, {15'h0, rf_we}, {15'h0, v.we});
        checkOutput({p, "_err"}, {15'h0, err}, {15'h0, v.err});
        if (v.we) begin
            checkOutput({p, "_waddr"}, {14'h0, rf_waddr}, {14'h0, v.rd});
            checkOutput({p, "_wdata"}, rf_wdata, v.wdata);
        end
        @(negedge clk);
        checkOutput({p, "_flags"}, {13'h0, flag_z, flag_v, flag_c}, {13'h0, v.z, v.v, v.c});
        checkOutput({p, "_pulse_off"}, {14'h0, rf_we, err}, 16'h0000);
    endtask

    initial begin
        int accepts;
        int we_pulses;
        int stray;

        //          op    rd   imm  ui  ra       rb       chk ctrl    bn  exp_b    we  err wdata    z  v  c
        vecs[0]  = '{4'h0, 2'd3, 8'h00, 1'b0, 16'h7FFF, 16'h0001, 1'b1, 3'b010, 1'b0, 16'h0001, 1'b1, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0};
        vecs[1]  = '{4'h1, 2'd2, 8'h00, 1'b0, 16'h0005, 16'h0005, 1'b1, 3'b010, 1'b1, 16'h0005, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
        vecs[2]  = '{4'h8, 2'd3, 8'h00, 1'b0, 16'h0011, 16'h0000, 1'b1, 3'b111, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1};
        vecs[3]  = '{4'hC, 2'd3, 8'h00, 1'b0, 16'h1234, 16'h0001, 1'b0, 3'b000, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1};
        vecs[4]  = '{4'h2, 2'd2, 8'h00, 1'b0, 16'h0005, 16'h0005, 1'b1, 3'b000, 1'b0, 16'h0005, 1'b1, 1'b0, 16'h0005, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{4'h7, 2'd1, 8'h01, 1'b0, 16'hFFFE, 16'h7777, 1'b1, 3'b110, 1'b0, 16'h0001, 1'b1, 1'b0, 16'h0001, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{4'h7, 2'd1, 8'h80, 1'b0, 16'hFFFE, 16'h7777, 1'b1, 3'b110, 1'b0, 16'hFF80, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0};
        vecs[7]  = '{4'h8, 2'd3, 8'h00, 1'b0, 16'h0011, 16'h0005, 1'b1, 3'b111, 1'b0, 16'h0005, 1'b1, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{4'h0, 2'd0, 8'h00, 1'b0, 16'h0005, 16'hFFFB, 1'b1, 3'b010, 1'b0, 16'hFFFB, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
        vecs[9]  = '{4'h3, 2'd3, 8'h00, 1'b0, 16'h00F0, 16'h0F00, 1'b1, 3'b001, 1'b0, 16'h0F00, 1'b1, 1'b0, 16'h0FF0, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{4'h4, 2'd3, 8'h00, 1'b0, 16'h00FF, 16'h00FF, 1'b1, 3'b100, 1'b0, 16'h00FF, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0};
        vecs[11] = '{4'h5, 2'd3, 8'h00, 1'b0, 16'h0000, 16'h0000, 1'b1, 3'b101, 1'b0, 16'h0000, 1'b1, 1'b0, 16'hFFFF, 1'b0, 1'b0, 1'b0};
        vecs[12] = '{4'h6, 2'd3, 8'h00, 1'b0, 16'hFFFF, 16'h0001, 1'b1, 3'b011, 1'b1, 16'h0001, 1'b1, 1'b0, 16'h0001, 1'b0, 1'b0, 1'b1};
        vecs[13] = '{4'h0, 2'd3, 8'h80, 1'b1, 16'h0100, 16'h5555, 1'b1, 3'b010, 1'b0, 16'hFF80, 1'b1, 1'b0, 16'h0080, 1'b0, 1'b0, 1'b1};

        rf_mem[0] = 16'h0000;
        rf_mem[1] = 16'h0000;
        rf_mem[2] = 16'h0000;
        rf_mem[3] = 16'h0000;
        rst_n = 1'b0;
        req_valid = 1'b0;
        req_op = 4'h0;
        req_rs = 2'd0;
        req_rt = 2'd0;
        req_rd = 2'd0;
        req_imm = 8'h00;
        req_use_imm = 1'b0;

        repeat (2) @(negedge clk);
        checkOutput("reset_ready", {15'h0, req_ready}, 16'h0001);
        checkOutput("reset_pulses", {14'h0, rf_we, err}, 16'h0000);
        checkOutput("reset_flags", {13'h0, flag_z, flag_v, flag_c}, 16'h0000);
        checkOutput("reset_alu_a", alu_a, 16'h0000);
        checkOutput("reset_alu_ctrl", {12'h0, alu_ctrl, alu_bnegate}, 16'h0000);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < NVEC; i++) begin
            applyStimulus(i);
        end

        // Reset in EXEC: the op vanishes and the carry left by the last vector is cleared.
        rf_mem[1] = 16'h0005;
        rf_mem[2] = 16'h0007;
        req_op = 4'h0;
        req_rs = 2'd1;
        req_rt = 2'd2;
        req_rd = 2'd3;
        req_use_imm = 1'b0;
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        checkOutput("midreset_ready", {15'h0, req_ready}, 16'h0001);
        checkOutput("midreset_pulses", {14'h0, rf_we, err}, 16'h0000);
        checkOutput("midreset_flags", {13'h0, flag_z, flag_v, flag_c}, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        stray = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (rf_we || err || !req_ready) stray++;
        end
        checkOutput("midreset_quiet", stray[15:0], 16'h0000);

        // Continuous req_valid: accepted only on every fourth cycle.
        rf_mem[1] = 16'h0001;
        rf_mem[2] = 16'h0002;
        req_valid = 1'b1;
        accepts = 0;
        we_pulses = 0;
        for (int i = 0; i < 12; i++) begin
            if (req_ready && req_valid) accepts++;
            if (rf_we) we_pulses++;
            @(negedge clk);
        end
        req_valid = 1'b0;
        checkOutput("b2b_accepts", accepts[15:0], 16'd3);
        checkOutput("b2b_writes", we_pulses[15:0], 16'd3);
        @(negedge clk);
        checkOutput("b2b_flags", {13'h0, flag_z, flag_v, flag_c}, 16'h0000);
        checkOutput("b2b_wdata", rf_wdata, 16'h0003);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
